// File: rtl/hazard_controller.sv
// hazard_controller: central pipeline sequencer. Resolves data-cache waits,
// taken redirects, load-use hazards and instruction misses into one
// priority-ordered set of latch stall/flush controls and a PC enable per
// cycle, owns the registered processor halt, and keeps saturating
// performance counters.
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_ihit,
  input  logic             i_dhit,
  input  logic             i_dmem_req,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_wsel,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_mem_redirect,
  input  logic             i_wb_halt,
  output logic             o_pc_en,
  output logic             o_fl_stall,
  output logic             o_fl_flush,
  output logic             o_dl_stall,
  output logic             o_dl_flush,
  output logic             o_el_stall,
  output logic             o_el_flush,
  output logic             o_ml_stall,
  output logic             o_ml_flush,
  output logic             o_halt,
  output logic [CNT_W-1:0] o_cnt_cycles,
  output logic [CNT_W-1:0] o_cnt_mwait,
  output logic [CNT_W-1:0] o_cnt_luse,
  output logic [CNT_W-1:0] o_cnt_redirect,
  output logic [CNT_W-1:0] o_cnt_imiss
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nextState;
  logic             w_memWait;
  logic             w_loadUse;
  logic             w_ruleMwait;
  logic             w_ruleRedirect;
  logic             w_ruleLuse;
  logic             w_ruleImiss;
  logic [CNT_W-1:0] r_cntCycles;
  logic [CNT_W-1:0] r_cntMwait;
  logic [CNT_W-1:0] r_cntLuse;
  logic [CNT_W-1:0] r_cntRedirect;
  logic [CNT_W-1:0] r_cntImiss;

  assign w_memWait = i_dmem_req & ~i_dhit;
  assign w_loadUse = i_ex_memread & (i_ex_wsel != 5'd0) &
                     ((i_ex_wsel == i_id_rs) | (i_id_uses_rt & (i_ex_wsel == i_id_rt)));

  // State register; halt can only be left through reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_nextState;
  end

  // Priority decision: data wait, redirect, load-use, fetch miss, advance.
  always_comb begin
    w_nextState    = r_state;
    o_pc_en        = 1'b0;
    o_fl_stall     = 1'b0;
    o_fl_flush     = 1'b0;
    o_dl_stall     = 1'b0;
    o_dl_flush     = 1'b0;
    o_el_stall     = 1'b0;
    o_el_flush     = 1'b0;
    o_ml_stall     = 1'b0;
    o_ml_flush     = 1'b0;
    w_ruleMwait    = 1'b0;
    w_ruleRedirect = 1'b0;
    w_ruleLuse     = 1'b0;
    w_ruleImiss    = 1'b0;
    if (r_state == HALTED) begin
      o_fl_stall = 1'b1;
      o_dl_stall = 1'b1;
      o_el_stall = 1'b1;
      o_ml_stall = 1'b1;
    end else begin
      if (i_wb_halt && !w_memWait) w_nextState = HALTED;
      if (w_memWait) begin
        w_ruleMwait = 1'b1;
        o_fl_stall  = 1'b1;
        o_dl_stall  = 1'b1;
        o_el_stall  = 1'b1;
        o_ml_flush  = 1'b1;
      end else if (i_mem_redirect) begin
        w_ruleRedirect = 1'b1;
        o_pc_en        = 1'b1;
        o_fl_flush     = 1'b1;
        o_dl_flush     = 1'b1;
        o_el_flush     = 1'b1;
      end else if (w_loadUse) begin
        w_ruleLuse = 1'b1;
        o_fl_stall = 1'b1;
        o_dl_flush = 1'b1;
      end else if (!i_ihit) begin
        w_ruleImiss = 1'b1;
        o_fl_flush  = 1'b1;
      end else begin
        o_pc_en = 1'b1;
      end
    end
  end

  // Saturating performance counters, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cntCycles   <= '0;
      r_cntMwait    <= '0;
      r_cntLuse     <= '0;
      r_cntRedirect <= '0;
      r_cntImiss    <= '0;
    end else if (r_state == RUN) begin
      if (r_cntCycles != '1)                    r_cntCycles   <= r_cntCycles + ONE;
      if (w_ruleMwait && r_cntMwait != '1)       r_cntMwait    <= r_cntMwait + ONE;
      if (w_ruleLuse && r_cntLuse != '1)         r_cntLuse     <= r_cntLuse + ONE;
      if (w_ruleRedirect && r_cntRedirect != '1) r_cntRedirect <= r_cntRedirect + ONE;
      if (w_ruleImiss && r_cntImiss != '1)       r_cntImiss    <= r_cntImiss + ONE;
    end
  end

  assign o_halt         = (r_state == HALTED);
  assign o_cnt_cycles   = r_cntCycles;
  assign o_cnt_mwait    = r_cntMwait;
  assign o_cnt_luse     = r_cntLuse;
  assign o_cnt_redirect = r_cntRedirect;
  assign o_cnt_imiss    = r_cntImiss;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: a behavioural model predicts each
// cycle's controls and counter values; predictions are queued when the
// stimulus is driven and popped when the outputs are sampled. A second
// instance with 4-bit counters exercises saturation on the same stimulus.
module tb_hazard_controller;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dmemReq, exMemread, idUsesRt, memRedirect, wbHalt;
  logic [4:0] exWsel, idRs, idRt;

  logic        pcEn, flS, flF, dlS, dlF, elS, elF, mlS, mlF, halt;
  logic [31:0] cCyc, cMw, cLu, cRd, cIm;
  logic        sPcEn, sFlS, sFlF, sDlS, sDlF, sElS, sElF, sMlS, sMlF, sHalt;
  logic [3:0]  sCyc, sMw, sLu, sRd, sIm;

  typedef struct {
    logic [8:0] ctl;
    logic       halt;
    int         cyc, mw, lu, rd, im;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  logic mHalted;
  int   mCyc, mMw, mLu, mRd, mIm;

  always #5 CLK = ~CLK;

  hazard_controller #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .i_ihit(ihit), .i_dhit(dhit), .i_dmem_req(dmemReq),
    .i_ex_memread(exMemread), .i_ex_wsel(exWsel), .i_id_rs(idRs), .i_id_rt(idRt),
    .i_id_uses_rt(idUsesRt), .i_mem_redirect(memRedirect), .i_wb_halt(wbHalt),
    .o_pc_en(pcEn), .o_fl_stall(flS), .o_fl_flush(flF), .o_dl_stall(dlS),
    .o_dl_flush(dlF), .o_el_stall(elS), .o_el_flush(elF), .o_ml_stall(mlS),
    .o_ml_flush(mlF), .o_halt(halt), .o_cnt_cycles(cCyc), .o_cnt_mwait(cMw),
    .o_cnt_luse(cLu), .o_cnt_redirect(cRd), .o_cnt_imiss(cIm)
  );

  hazard_controller #(.CNT_W(4)) dutSat (
    .CLK(CLK), .nRST(nRST), .i_ihit(ihit), .i_dhit(dhit), .i_dmem_req(dmemReq),
    .i_ex_memread(exMemread), .i_ex_wsel(exWsel), .i_id_rs(idRs), .i_id_rt(idRt),
    .i_id_uses_rt(idUsesRt), .i_mem_redirect(memRedirect), .i_wb_halt(wbHalt),
    .o_pc_en(sPcEn), .o_fl_stall(sFlS), .o_fl_flush(sFlF), .o_dl_stall(sDlS),
    .o_dl_flush(sDlF), .o_el_stall(sElS), .o_el_flush(sElF), .o_ml_stall(sMlS),
    .o_ml_flush(sMlF), .o_halt(sHalt), .o_cnt_cycles(sCyc), .o_cnt_mwait(sMw),
    .o_cnt_luse(sLu), .o_cnt_redirect(sRd), .o_cnt_imiss(sIm)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : v;
  endfunction

  // Pop the oldest prediction and compare it with both instances.
  task automatic popAndCheck();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL queue: got empty expected entry");
      return;
    end
    e = expQ.pop_front();
    checkOutput("ctl",      {23'd0, pcEn, flS, flF, dlS, dlF, elS, elF, mlS, mlF}, {23'd0, e.ctl});
    checkOutput("halt",     {31'd0, halt}, {31'd0, e.halt});
    checkOutput("cycles",   cCyc, e.cyc);
    checkOutput("mwait",    cMw, e.mw);
    checkOutput("luse",     cLu, e.lu);
    checkOutput("redirect", cRd, e.rd);
    checkOutput("imiss",    cIm, e.im);
    checkOutput("satCtl",   {23'd0, sPcEn, sFlS, sFlF, sDlS, sDlF, sElS, sElF, sMlS, sMlF}, {23'd0, e.ctl});
    checkOutput("satCycles", {28'd0, sCyc}, sat4(e.cyc));
    checkOutput("satMwait",  {28'd0, sMw}, sat4(e.mw));
    checkOutput("satLuse",   {28'd0, sLu}, sat4(e.lu));
    checkOutput("satRedir",  {28'd0, sRd}, sat4(e.rd));
    checkOutput("satImiss",  {28'd0, sIm}, sat4(e.im));
  endtask

  function automatic exp_t snapshot(input logic [8:0] ctl);
    exp_t e;
    e.ctl = ctl; e.halt = mHalted;
    e.cyc = mCyc; e.mw = mMw; e.lu = mLu; e.rd = mRd; e.im = mIm;
    return e;
  endfunction

  // One clock of stimulus: drive at posedge+1, predict, sample at negedge.
  task automatic applyStimulus(input logic ih, input logic dh, input logic dreq,
                               input logic exmr, input logic [4:0] exw,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic redir, input logic wbh);
    logic       mw, lu;
    int         rule;
    logic [8:0] ctl;
    ihit = ih; dhit = dh; dmemReq = dreq; exMemread = exmr; exWsel = exw;
    idRs = rs; idRt = rt; idUsesRt = urt; memRedirect = redir; wbHalt = wbh;
    mw = dreq & ~dh;
    lu = exmr && exw != 0 && (exw == rs || (urt && exw == rt));
    if (mHalted)      begin rule = 0; ctl = 9'b0_1010_1010; end
    else if (mw)      begin rule = 1; ctl = 9'b0_1010_1001; end
    else if (redir)   begin rule = 2; ctl = 9'b1_0101_0100; end
    else if (lu)      begin rule = 3; ctl = 9'b0_1001_0000; end
    else if (!ih)     begin rule = 4; ctl = 9'b0_0100_0000; end
    else              begin rule = 5; ctl = 9'b1_0000_0000; end
    expQ.push_back(snapshot(ctl));
    @(negedge CLK);
    popAndCheck();
    @(posedge CLK);
    #1;
    if (!mHalted) begin
      mCyc++;
      if (rule == 1) mMw++;
      if (rule == 2) mRd++;
      if (rule == 3) mLu++;
      if (rule == 4) mIm++;
      if (wbh && !mw) mHalted = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset: outputs checked before any clock edge.
  task automatic resetDut();
    nRST = 1'b0;
    ihit = 1; dhit = 1; dmemReq = 0; exMemread = 0; exWsel = 0;
    idRs = 0; idRt = 0; idUsesRt = 0; memRedirect = 0; wbHalt = 0;
    mHalted = 1'b0; mCyc = 0; mMw = 0; mLu = 0; mRd = 0; mIm = 0;
    expQ.push_back(snapshot(9'b1_0000_0000));
    #1;
    popAndCheck();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    #2;
    $display("[TB] reset state");
    resetDut();

    $display("[TB] load-use");
    applyStimulus(1, 1, 0, 1, 5, 5, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 7, 3, 7, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 7, 3, 7, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 9, 9, 0, 0, 0, 0);
    idle(1);

    $display("[TB] cache wait");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] redirect vs wait");
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 4, 4, 0, 0, 1, 0);
    idle(1);

    $display("[TB] mid-stall reset");
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    resetDut();

    $display("[TB] i-miss");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] random run");
    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, 1'b0);

    $display("[TB] halt");
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 5, 5, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    resetDut();
    idle(2);

    $display("[TB] saturation");
    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
